// File: rtl/cv32e40p_wb_port_arbiter.sv
// cv32e40p_wb_port_arbiter
// Shares the EX-stage register-file write port between core results and
// X-interface (coprocessor) results. X results wait in a small in-order FIFO
// and take the port with priority. A bounded streak counter guarantees the
// core a grant after MAX_X_STREAK consecutive X grants while it is waiting.
//
// Optional feature: define CV32E40P_WB_ARB_BYPASS_EN to let an X result that
// arrives while the FIFO is empty be written in its acceptance cycle.
//
// The outputs are combinational from the FIFO state and the inputs, because
// the EX stage stalls on core_we_i & ~core_gnt_o within the same cycle.

module cv32e40p_wb_port_arbiter #(
    parameter int unsigned X_FIFO_DEPTH = 2,
    parameter int unsigned MAX_X_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_we_i,
    input  logic [5:0]  core_waddr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,

    input  logic        x_result_valid_i,
    output logic        x_result_ready_o,
    input  logic        x_result_we_i,
    input  logic [4:0]  x_result_rd_i,
    input  logic [31:0] x_result_data_i,
    input  logic [3:0]  x_result_id_i,

    output logic        rf_we_o,
    output logic [5:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,

    output logic        x_retired_o,
    output logic [3:0]  x_retired_id_o,
    output logic        x_pending_o
);

    localparam int unsigned PTR_W    = (X_FIFO_DEPTH > 1) ? $clog2(X_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STREAK_W = $clog2(MAX_X_STREAK + 1);

    // One queued X result; the address is widened to 6 bits on the way out.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  id;
    } x_entry_t;

    x_entry_t            fifo_q [X_FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    x_entry_t head;
    x_entry_t entry_in;
    logic     fifo_full;
    logic     fifo_empty;
    logic     x_is_drop;
    logic     bypass_cand;
    logic     x_cand;
    logic     x_grant;
    logic     core_grant;
    logic     bypass_grant;
    logic     accept;
    logic     drop_retire;
    logic     push;
    logic     pop;

    // Arbitration, acceptance and the FIFO push/pop decision.
    always_comb begin
        fifo_full  = (count_q == CNT_W'(X_FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        head       = fifo_q[rptr_q];

        entry_in.rd   = x_result_rd_i;
        entry_in.data = x_result_data_i;
        entry_in.id   = x_result_id_i;

        // x0 targets and non-writing results never occupy a FIFO slot.
        x_is_drop = ~x_result_we_i | (x_result_rd_i == 5'd0);

`ifdef CV32E40P_WB_ARB_BYPASS_EN
        bypass_cand = ~rst & x_result_valid_i & ~x_is_drop & fifo_empty;
`else
        bypass_cand = 1'b0;
`endif

        x_cand     = ~rst & (~fifo_empty | bypass_cand);
        x_grant    = x_cand & (~core_we_i | (streak_q < STREAK_W'(MAX_X_STREAK)));
        core_grant = ~rst & core_we_i & ~x_grant;

        // Only one retire per cycle: a drop cannot be accepted while X writes.
        x_result_ready_o = ~rst & ~fifo_full & ~(x_grant & x_is_drop);

        accept       = x_result_valid_i & x_result_ready_o;
        drop_retire  = accept & x_is_drop;
        // An X grant with an empty FIFO can only come from the bypass path.
        bypass_grant = x_grant & fifo_empty;
        push         = accept & ~x_is_drop & ~bypass_grant;
        pop          = x_grant & ~fifo_empty;
    end

    // Write-port mux and retire reporting.
    always_comb begin
        rf_we_o        = 1'b0;
        rf_waddr_o     = 6'd0;
        rf_wdata_o     = 32'd0;
        core_gnt_o     = 1'b0;
        x_retired_o    = 1'b0;
        x_retired_id_o = 4'd0;
        x_pending_o    = ~rst & ~fifo_empty;

        if (x_grant) begin
            rf_we_o     = 1'b1;
            x_retired_o = 1'b1;
            if (bypass_grant) begin
                rf_waddr_o     = 6'({1'b0, x_result_rd_i});
                rf_wdata_o     = x_result_data_i;
                x_retired_id_o = x_result_id_i;
            end else begin
                rf_waddr_o     = 6'({1'b0, head.rd});
                rf_wdata_o     = head.data;
                x_retired_id_o = head.id;
            end
        end else if (core_grant) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = core_waddr_i;
            rf_wdata_o = core_wdata_i;
            core_gnt_o = 1'b1;
        end

        if (drop_retire) begin
            x_retired_o    = 1'b1;
            x_retired_id_o = x_result_id_i;
        end
    end

    // Next pointer, occupancy and streak values.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        streak_d = streak_q;

        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The streak only counts X wins that made a waiting core lose.
        if (!core_we_i) begin
            streak_d = '0;
        end else if (x_grant) begin
            streak_d = streak_q + STREAK_W'(1);
        end else begin
            streak_d = '0;
        end
    end

    // Control state register; reset discards anything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            streak_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            streak_q <= streak_d;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= entry_in;
        end
    end

endmodule

// File: tb/tb_cv32e40p_wb_port_arbiter.sv
// Directed bench for cv32e40p_wb_port_arbiter: a table of single-cycle
// vectors applied in order, plus a hand-written starvation/full sequence.
// Inputs change on the falling edge and outputs are sampled 2 ns later.

module tb_cv32e40p_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_we = 1'b0;
    logic [5:0]  core_waddr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_gnt;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic        x_we = 1'b1;
    logic [4:0]  x_rd = 5'd1;
    logic [31:0] x_data = '0;
    logic [3:0]  x_id = '0;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        x_retired;
    logic [3:0]  x_retired_id;
    logic        x_pending;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cv32e40p_wb_port_arbiter #(
        .X_FIFO_DEPTH(2),
        .MAX_X_STREAK(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .core_we_i        (core_we),
        .core_waddr_i     (core_waddr),
        .core_wdata_i     (core_wdata),
        .core_gnt_o       (core_gnt),
        .x_result_valid_i (x_valid),
        .x_result_ready_o (x_ready),
        .x_result_we_i    (x_we),
        .x_result_rd_i    (x_rd),
        .x_result_data_i  (x_data),
        .x_result_id_i    (x_id),
        .rf_we_o          (rf_we),
        .rf_waddr_o       (rf_waddr),
        .rf_wdata_o       (rf_wdata),
        .x_retired_o      (x_retired),
        .x_retired_id_o   (x_retired_id),
        .x_pending_o      (x_pending)
    );

    typedef struct {
        logic        rst;
        logic        cwe;
        logic [5:0]  caddr;
        logic [31:0] cdata;
        logic        xv;
        logic        xwe;
        logic [4:0]  xrd;
        logic [31:0] xdata;
        logic [3:0]  xid;
        logic        e_gnt;
        logic        e_rdy;
        logic        e_we;
        logic [5:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ret;
        logic [3:0]  e_id;
        logic        e_pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst_v, input logic cwe, input logic [5:0] caddr, input logic [31:0] cdata,
        input logic xv, input logic xwe, input logic [4:0] xrd, input logic [31:0] xdata,
        input logic [3:0] xid,
        input logic e_gnt, input logic e_rdy, input logic e_we, input logic [5:0] e_addr,
        input logic [31:0] e_data, input logic e_ret, input logic [3:0] e_id, input logic e_pend);
        vec_t v;
        v.rst = rst_v;   v.cwe = cwe;     v.caddr = caddr;   v.cdata = cdata;
        v.xv = xv;       v.xwe = xwe;     v.xrd = xrd;       v.xdata = xdata;   v.xid = xid;
        v.e_gnt = e_gnt; v.e_rdy = e_rdy; v.e_we = e_we;     v.e_addr = e_addr; v.e_data = e_data;
        v.e_ret = e_ret; v.e_id = e_id;   v.e_pend = e_pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst        = v.rst;
        core_we    = v.cwe;
        core_waddr = v.caddr;
        core_wdata = v.cdata;
        x_valid    = v.xv;
        x_we       = v.xwe;
        x_rd       = v.xrd;
        x_data     = v.xdata;
        x_id       = v.xid;
    endtask

    initial begin
        logic [3:0] offer_id;
        logic [3:0] next_ret;
        logic       exp_core;
        logic       exp_rdy;
        logic [45:0] exp_s;
        logic [45:0] act_s;

        // rst cwe caddr cdata | xv xwe xrd xdata xid | gnt rdy we addr data ret id pend
        // Reset holds every output low, even with requests present.
        tbl.push_back(mk(1, 1, 6'd5, 32'hDEADBEEF, 0, 1, 5'd1, 0, 0,   0, 0, 0, 6'd0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 6'd0, 32'h0,       1, 1, 5'd3, 32'h9, 1, 0, 0, 0, 6'd0, 32'h0, 0, 0, 0));
        // Core alone after reset release: zero-latency grant.
        tbl.push_back(mk(0, 1, 6'd5, 32'hDEADBEEF, 0, 1, 5'd1, 0, 0,   1, 1, 1, 6'd5, 32'hDEADBEEF, 0, 0, 0));
`ifndef CV32E40P_WB_ARB_BYPASS_EN
        // X priority: accepted at N (core wins N), X writes at N+1, core at N+2.
        tbl.push_back(mk(0, 1, 6'd8, 32'hAAAA, 1, 1, 5'd7, 32'h1234, 3, 1, 1, 1, 6'd8, 32'hAAAA, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'd8, 32'hAAAA, 0, 1, 5'd1, 0, 0,        0, 1, 1, 6'd7, 32'h1234, 1, 3, 1));
        tbl.push_back(mk(0, 1, 6'd8, 32'hAAAA, 0, 1, 5'd1, 0, 0,        1, 1, 1, 6'd8, 32'hAAAA, 0, 0, 0));
`else
        // Bypass: the X result is written in its acceptance cycle.
        tbl.push_back(mk(0, 1, 6'd8, 32'hAAAA, 1, 1, 5'd7, 32'h1234, 3, 0, 1, 1, 6'd7, 32'h1234, 1, 3, 0));
        tbl.push_back(mk(0, 1, 6'd8, 32'hAAAA, 0, 1, 5'd1, 0, 0,        1, 1, 1, 6'd8, 32'hAAAA, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'd8, 32'hAAAA, 0, 1, 5'd1, 0, 0,        1, 1, 1, 6'd8, 32'hAAAA, 0, 0, 0));
`endif
        // Drops: rd=0, then we=0 with id 9; retire in the acceptance cycle.
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 1, 1, 5'd0, 32'h55, 4, 0, 1, 0, 6'd0, 32'h0, 1, 4, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 1, 0, 5'd9, 32'h66, 9, 0, 1, 0, 6'd0, 32'h0, 1, 9, 0));
`ifndef CV32E40P_WB_ARB_BYPASS_EN
        // Queue one result, then offer a drop during its write: ready blocked.
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 1, 1, 5'd10, 32'h100, 5, 0, 1, 0, 6'd0,  32'h0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 1, 0, 5'd3,  32'h0,   6, 0, 0, 1, 6'd10, 32'h100, 1, 5, 1));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 1, 0, 5'd3,  32'h0,   6, 0, 1, 0, 6'd0,  32'h0,   1, 6, 0));
        // Reset with an entry queued: it is discarded without a retire.
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 1, 1, 5'd12, 32'h77, 7, 0, 1, 0, 6'd0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 6'd0, 32'h0, 0, 1, 5'd1,  32'h0,  0, 0, 0, 0, 6'd0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 0, 1, 5'd1,  32'h0,  0, 0, 1, 0, 6'd0, 32'h0, 0, 0, 0));
        // Without bypass a lone X result is written one cycle after acceptance.
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 1, 1, 5'd2, 32'hB, 4'hB, 0, 1, 0, 6'd0, 32'h0, 0, 0,    0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 0, 1, 5'd1, 32'h0, 0,    0, 1, 1, 6'd2, 32'hB, 1, 4'hB, 1));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 0, 1, 5'd1, 32'h0, 0,    0, 1, 0, 6'd0, 32'h0, 0, 0,    0));
`else
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 1, 1, 5'd2, 32'hB, 4'hB, 0, 1, 1, 6'd2, 32'hB, 1, 4'hB, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0, 0, 1, 5'd1, 32'h0, 0,    0, 1, 0, 6'd0, 32'h0, 0, 0,    0));
`endif

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #2;
            check($sformatf("vec%0d", i),
                  64'({core_gnt, x_ready, rf_we, rf_waddr, rf_wdata, x_retired, x_retired_id, x_pending}),
                  64'({tbl[i].e_gnt, tbl[i].e_rdy, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_data,
                       tbl[i].e_ret, tbl[i].e_id, tbl[i].e_pend}));
        end

        // Starvation bound and full FIFO: X offered every cycle, core always waiting.
        @(negedge clk);
        rst     = 1'b1;
        x_valid = 1'b0;
        core_we = 1'b0;
        @(negedge clk);
        offer_id = 4'd0;
        next_ret = 4'd0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            rst        = 1'b0;
            core_we    = 1'b1;
            core_waddr = 6'd33;
            core_wdata = 32'hC0DE0000 | 32'(c);
            x_valid    = 1'b1;
            x_we       = 1'b1;
            x_rd       = {1'b1, offer_id};
            x_data     = 32'h5A000000 | 32'(offer_id);
            x_id       = offer_id;
            #2;
`ifdef CV32E40P_WB_ARB_BYPASS_EN
            exp_core = ((c % 5) == 4);
            exp_rdy  = !(c >= 10 && (c % 5) == 0);
`else
            exp_core = ((c % 5) == 0);
            exp_rdy  = !(c >= 6 && (c % 5) == 1);
`endif
            if (exp_core) begin
                exp_s = {1'b1, exp_rdy, 1'b0, 4'd0, 1'b1, 6'd33, 32'hC0DE0000 | 32'(c)};
            end else begin
                exp_s = {1'b0, exp_rdy, 1'b1, next_ret, 1'b1, {2'b01, next_ret},
                         32'h5A000000 | 32'(next_ret)};
                next_ret = next_ret + 4'd1;
            end
            act_s = {core_gnt, x_ready, x_retired, x_retired_id, rf_we, rf_waddr, rf_wdata};
            check($sformatf("streak_c%0d", c), 64'(act_s), 64'(exp_s));
            if (exp_rdy) offer_id = offer_id + 4'd1;
        end

        @(negedge clk);
        x_valid = 1'b0;
        core_we = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
